// File: rtl/lsu_mem_master_if.sv
// Request/response channel between the MEM stage and the LSU, and the
// LSU's view of the unified memory data port.
interface lsu_req_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        resp_split;

  modport master (output req_valid, req_we, req_type, req_addr, req_wdata,
                  input  req_ready, resp_valid, resp_rdata, resp_err, resp_split);
  modport slave  (input  req_valid, req_we, req_type, req_addr, req_wdata,
                  output req_ready, resp_valid, resp_rdata, resp_err, resp_split);
endinterface

interface lsu_dm_if;
  logic        DMWr;
  logic        DMRd;
  logic [31:0] dm_addr;
  logic [31:0] dm_din;
  logic [2:0]  DMType;
  logic [31:0] dm_dout;

  modport master (output DMWr, DMRd, dm_addr, dm_din, DMType, input  dm_dout);
  modport slave  (input  DMWr, DMRd, dm_addr, dm_din, DMType, output dm_dout);
endinterface

// File: rtl/lsu_mem_master.sv
// Single-outstanding load/store initiator; misaligned half/word accesses are
// optionally split into byte accesses and reassembled little-endian.
module lsu_mem_master #(
  parameter bit          SPLIT_EN  = 1'b1,
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic       clk,
  input  logic       rstn,
  lsu_req_if.slave   req,
  lsu_dm_if.master   dm
);
  typedef enum logic [1:0] {IDLE, ISSUE, SPLIT, DONE} state_t;

  state_t      r_state, w_next;
  logic        r_we, r_err, r_split;
  logic [2:0]  r_type;
  logic [1:0]  r_idx, r_last;
  logic [31:0] r_addr, r_wdata, r_asm, r_rdata;

  logic [2:0]  w_type;
  logic [1:0]  w_last;
  logic        w_mis, w_oob, w_err, w_acc;
  logic [31:0] w_end, w_asm, w_ext;
  logic [7:0]  w_wbyte;

  // Request classification; w_last is access width minus one.
  always_comb begin
    w_type = (req.req_type > 3'd4) ? 3'd0 : req.req_type;
    case (w_type)
      3'd0:      w_last = 2'd3;
      3'd1, 3'd2: w_last = 2'd1;
      default:   w_last = 2'd0;
    endcase
    w_mis = ((w_last == 2'd3) && (req.req_addr[1:0] != 2'b00)) ||
            ((w_last == 2'd1) && req.req_addr[0]);
    w_end = req.req_addr + {30'd0, w_last};
    // A wrapped end address is smaller than the start address.
    w_oob = (w_end < req.req_addr) || ({1'b0, w_end} >= 33'(MEM_BYTES));
    w_err = w_oob || (w_mis && !SPLIT_EN);
  end

  assign w_acc = req.req_valid && (r_state == IDLE);

  always_comb begin
    w_asm = r_asm;
    w_asm[{r_idx, 3'b000} +: 8] = dm.dm_dout[7:0];
    case (r_type)
      3'd1:    w_ext = {{16{w_asm[15]}}, w_asm[15:0]};
      3'd2:    w_ext = {16'd0, w_asm[15:0]};
      default: w_ext = w_asm;
    endcase
    w_wbyte = r_wdata[{r_idx, 3'b000} +: 8];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_acc) w_next = w_err ? DONE : (w_mis ? SPLIT : ISSUE);
      ISSUE:   w_next = DONE;
      SPLIT:   if (r_idx == r_last) w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // r_rdata only changes on the edge entering DONE, so it holds between responses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we    <= 1'b0;
      r_type  <= 3'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_idx   <= 2'd0;
      r_last  <= 2'd0;
      r_err   <= 1'b0;
      r_split <= 1'b0;
      r_asm   <= 32'd0;
      r_rdata <= 32'd0;
    end else begin
      case (r_state)
        IDLE: if (w_acc) begin
          r_we    <= req.req_we;
          r_type  <= w_type;
          r_addr  <= req.req_addr;
          r_wdata <= req.req_wdata;
          r_idx   <= 2'd0;
          r_last  <= w_last;
          r_err   <= w_err;
          r_split <= w_mis && !w_err;
          r_asm   <= 32'd0;
          if (w_err) r_rdata <= 32'd0;
        end
        ISSUE: r_rdata <= r_we ? 32'd0 : dm.dm_dout;
        SPLIT: begin
          r_asm <= w_asm;
          r_idx <= r_idx + 2'd1;
          if (r_idx == r_last) r_rdata <= r_we ? 32'd0 : w_ext;
        end
        default: ;
      endcase
    end
  end

  // Memory port is purely state-decoded, so reset drops the enables at once.
  always_comb begin
    req.req_ready  = (r_state == IDLE);
    req.resp_valid = (r_state == DONE);
    req.resp_err   = (r_state == DONE) && r_err;
    req.resp_split = (r_state == DONE) && r_split;
    req.resp_rdata = r_rdata;
    dm.DMWr    = 1'b0;
    dm.DMRd    = 1'b0;
    dm.dm_addr = 32'd0;
    dm.dm_din  = 32'd0;
    dm.DMType  = 3'd0;
    case (r_state)
      ISSUE: begin
        dm.DMWr    = r_we;
        dm.DMRd    = !r_we;
        dm.dm_addr = r_addr;
        dm.dm_din  = r_wdata;
        dm.DMType  = r_type;
      end
      SPLIT: begin
        dm.DMWr    = r_we;
        dm.DMRd    = !r_we;
        dm.dm_addr = r_addr + {30'd0, r_idx};
        dm.dm_din  = r_we ? {24'd0, w_wbyte} : 32'd0;
        dm.DMType  = r_we ? 3'd3 : 3'd4;
      end
      default: ;
    endcase
  end
endmodule
